// File: rtl/f56_bus_arbiter.sv
// -----------------------------------------------------------------------------
// f56_bus_arbiter
//
// Round-robin arbiter and pin multiplexer for the shared FALC56 local bus.
// Up to NUM_REQ masters (Wishbone bridge, interrupt engine, init sequencer)
// each raise a level request, wait for their one-hot grant, drive their own
// copy of the bus signals and then drop the request. The owner's signals are
// registered onto the FALC56 pins; at all other times the pins are parked
// idle. Every release is followed by GAP_CYCLES of turnaround before the
// next grant.
//
// Optional feature, macro F56_ARB_TIMEOUT_EN:
//   defined     -> a grant held for MAX_HOLD cycles is revoked, TIMEOUT_O
//                  pulses for one cycle and the bus goes through the gap.
//   not defined -> no hold counter, a grant lasts until release,
//                  TIMEOUT_O is tied low.
//
// Ports:
//   PHY_CLK33_I     bus clock, all logic on the rising edge
//   PHY_RST_I       synchronous active-high reset
//   REQ_I           per-master request (level)
//   GNT_O           one-hot grant (registered)
//   M_BADD_I        per-master address/data, master i at [8i+7:8i]
//   M_BADD_DIR_I    per-master drive enable
//   M_ALE_I         per-master ALE
//   M_RDn_I         per-master RDn
//   M_WRn_I         per-master WRn
//   M_CSn_I         per-master CSn pair, master i at [2i+1:2i]
//   F56_*_O         registered FALC56 pins
//   BUSY_O          high while granted or in turnaround
//   OWNER_O         index of the current or last owner
//   TIMEOUT_O       one-cycle pulse on a forced revoke
// -----------------------------------------------------------------------------
module f56_bus_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int OWN_W      = 2,
  parameter int GAP_CYCLES = 2,
  parameter int MAX_HOLD   = 64
) (
  input  logic                   PHY_CLK33_I,
  input  logic                   PHY_RST_I,
  input  logic [NUM_REQ-1:0]     REQ_I,
  output logic [NUM_REQ-1:0]     GNT_O,
  input  logic [8*NUM_REQ-1:0]   M_BADD_I,
  input  logic [NUM_REQ-1:0]     M_BADD_DIR_I,
  input  logic [NUM_REQ-1:0]     M_ALE_I,
  input  logic [NUM_REQ-1:0]     M_RDn_I,
  input  logic [NUM_REQ-1:0]     M_WRn_I,
  input  logic [2*NUM_REQ-1:0]   M_CSn_I,
  output logic [7:0]             F56_BADD_O,
  output logic                   F56_BADD_DIR_O,
  output logic                   F56_ALE_O,
  output logic                   F56_RDn_O,
  output logic                   F56_WRn_O,
  output logic [1:0]             F56_CSn_O,
  output logic                   BUSY_O,
  output logic [OWN_W-1:0]       OWNER_O,
  output logic                   TIMEOUT_O
);

  // Parked pin values: nothing driven, all strobes inactive.
  localparam logic [7:0] IDLE_BADD = 8'h00;
  localparam logic [1:0] IDLE_CSN  = 2'b11;

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t               r_state, w_state_next;
  logic [NUM_REQ-1:0]   r_gnt, w_gnt_next;
  logic [OWN_W-1:0]     r_owner, w_owner_next;
  logic [OWN_W-1:0]     r_ptr, w_ptr_next;
  logic [GAP_W-1:0]     r_gap, w_gap_next;

  logic [7:0]           r_badd, w_badd_next;
  logic                 r_badd_dir, w_badd_dir_next;
  logic                 r_ale, w_ale_next;
  logic                 r_rdn, w_rdn_next;
  logic                 r_wrn, w_wrn_next;
  logic [1:0]           r_csn, w_csn_next;

`ifdef F56_ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD);
  // Counter value seen at the edge that completes MAX_HOLD cycles of grant.
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0]    r_hold, w_hold_next;
  logic                 r_timeout, w_timeout_next;
`else
  // The hold limit only matters when the revoke logic is built.
  logic                 w_unused_max_hold;
  assign w_unused_max_hold = (MAX_HOLD > 0);
`endif

  // ---------------------------------------------------------------------------
  // Per-master bus signals unpacked into arrays so the owner mux is a plain
  // array index.
  // ---------------------------------------------------------------------------
  logic [7:0] w_m_badd [NUM_REQ];
  logic [1:0] w_m_csn  [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_m_badd[gi] = M_BADD_I[8*gi +: 8];
      assign w_m_csn[gi]  = M_CSn_I[2*gi +: 2];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Round-robin winner. Requests above the pointer take precedence; if there
  // are none the search wraps and the lowest set request wins.
  // ---------------------------------------------------------------------------
  logic [NUM_REQ-1:0] w_req_hi;
  logic [NUM_REQ-1:0] w_pick;
  logic [OWN_W-1:0]   w_win_idx;
  logic               w_any_req;
  logic               w_owner_req;

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_mask
      assign w_req_hi[gi] = REQ_I[gi] & (OWN_W'(gi) > r_ptr);
    end
  endgenerate

  assign w_any_req   = |REQ_I;
  assign w_pick      = (|w_req_hi) ? w_req_hi : REQ_I;
  assign w_owner_req = REQ_I[r_owner];

  // Lowest set bit of w_pick; scanning downward lets the lowest index win.
  always_comb begin
    w_win_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_pick[i]) begin
        w_win_idx = OWN_W'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  logic w_do_arb;

  always_comb begin
    w_state_next    = r_state;
    w_gnt_next      = r_gnt;
    w_owner_next    = r_owner;
    w_ptr_next      = r_ptr;
    w_gap_next      = r_gap;
    w_do_arb        = 1'b0;
`ifdef F56_ARB_TIMEOUT_EN
    w_hold_next     = r_hold;
    w_timeout_next  = 1'b0;
`endif
    // Pins park idle unless the owner is actively holding the bus.
    w_badd_next     = IDLE_BADD;
    w_badd_dir_next = 1'b0;
    w_ale_next      = 1'b0;
    w_rdn_next      = 1'b1;
    w_wrn_next      = 1'b1;
    w_csn_next      = IDLE_CSN;

    case (r_state)
      ST_IDLE: begin
        w_do_arb = w_any_req;
      end

      ST_GRANT: begin
        if (!w_owner_req) begin
          // A release takes priority over a timeout on the same edge.
          w_gnt_next   = '0;
          w_gap_next   = '0;
          w_state_next = ST_GAP;
        end
`ifdef F56_ARB_TIMEOUT_EN
        else if (r_hold == HOLD_LAST) begin
          // Forced revoke. The pointer stays on the revoked owner so the
          // other masters are searched first at the next arbitration.
          w_gnt_next     = '0;
          w_gap_next     = '0;
          w_timeout_next = 1'b1;
          w_state_next   = ST_GAP;
        end
`endif
        else begin
`ifdef F56_ARB_TIMEOUT_EN
          w_hold_next     = r_hold + 1'b1;
`endif
          w_badd_next     = w_m_badd[r_owner];
          w_badd_dir_next = M_BADD_DIR_I[r_owner];
          w_ale_next      = M_ALE_I[r_owner];
          w_rdn_next      = M_RDn_I[r_owner];
          w_wrn_next      = M_WRn_I[r_owner];
          w_csn_next      = w_m_csn[r_owner];
        end
      end

      ST_GAP: begin
        w_gnt_next = '0;
        if (r_gap == GAP_LAST) begin
          w_gap_next   = '0;
          w_state_next = ST_IDLE;
          w_do_arb     = w_any_req;
        end else begin
          w_gap_next = r_gap + 1'b1;
        end
      end

      default: begin
        w_gnt_next   = '0;
        w_state_next = ST_IDLE;
      end
    endcase

    // Arbitration overrides the IDLE fallback chosen above.
    if (w_do_arb) begin
      w_gnt_next   = NUM_REQ'(1) << w_win_idx;
      w_owner_next = w_win_idx;
      w_ptr_next   = w_win_idx;
      w_state_next = ST_GRANT;
`ifdef F56_ARB_TIMEOUT_EN
      w_hold_next  = '0;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge PHY_CLK33_I) begin
    if (PHY_RST_I) begin
      r_state    <= ST_IDLE;
      r_gnt      <= '0;
      r_owner    <= '0;
      // Pointer at the top so master 0 is searched first after reset.
      r_ptr      <= OWN_W'(NUM_REQ - 1);
      r_gap      <= '0;
      r_badd     <= IDLE_BADD;
      r_badd_dir <= 1'b0;
      r_ale      <= 1'b0;
      r_rdn      <= 1'b1;
      r_wrn      <= 1'b1;
      r_csn      <= IDLE_CSN;
    end else begin
      r_state    <= w_state_next;
      r_gnt      <= w_gnt_next;
      r_owner    <= w_owner_next;
      r_ptr      <= w_ptr_next;
      r_gap      <= w_gap_next;
      r_badd     <= w_badd_next;
      r_badd_dir <= w_badd_dir_next;
      r_ale      <= w_ale_next;
      r_rdn      <= w_rdn_next;
      r_wrn      <= w_wrn_next;
      r_csn      <= w_csn_next;
    end
  end

`ifdef F56_ARB_TIMEOUT_EN
  always_ff @(posedge PHY_CLK33_I) begin
    if (PHY_RST_I) begin
      r_hold    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_hold    <= w_hold_next;
      r_timeout <= w_timeout_next;
    end
  end

  assign TIMEOUT_O = r_timeout;
`else
  assign TIMEOUT_O = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign GNT_O          = r_gnt;
  assign OWNER_O        = r_owner;
  assign BUSY_O         = (r_state != ST_IDLE);
  assign F56_BADD_O     = r_badd;
  assign F56_BADD_DIR_O = r_badd_dir;
  assign F56_ALE_O      = r_ale;
  assign F56_RDn_O      = r_rdn;
  assign F56_WRn_O      = r_wrn;
  assign F56_CSn_O      = r_csn;

endmodule

// File: tb/tb_f56_bus_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for f56_bus_arbiter (NUM_REQ=4, GAP_CYCLES=2, MAX_HOLD=64).
// A timer-based reference model (owner / age / gap countdown) predicts every
// output after every clock edge; directed steps cover the scenarios of
// interest and a random phase follows.
// -----------------------------------------------------------------------------
module tb_f56_bus_arbiter;

  localparam int N    = 4;
  localparam int GAP  = 2;
  localparam int HOLD = 64;
`ifdef F56_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam logic [13:0] PIN_IDLE = {8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11};

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] m_badd;
  logic [3:0]  m_dir, m_ale, m_rdn, m_wrn;
  logic [7:0]  m_csn;

  logic [3:0]  gnt;
  logic [7:0]  f_badd;
  logic        f_dir, f_ale, f_rdn, f_wrn;
  logic [1:0]  f_csn;
  logic        busy;
  logic [1:0]  owner;
  logic        tout;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          md_owner;     // -1 when nobody holds a grant
  int          md_age;       // edges since grant
  int          md_gap_left;  // turnaround edges still to go
  int          md_ptr;
  int          md_last;
  logic [13:0] md_pins;
  bit          md_to;

  always #5 clk = ~clk;

  f56_bus_arbiter #(
    .NUM_REQ(4), .OWN_W(2), .GAP_CYCLES(2), .MAX_HOLD(64)
  ) dut (
    .PHY_CLK33_I(clk),
    .PHY_RST_I(rst),
    .REQ_I(req),
    .GNT_O(gnt),
    .M_BADD_I(m_badd),
    .M_BADD_DIR_I(m_dir),
    .M_ALE_I(m_ale),
    .M_RDn_I(m_rdn),
    .M_WRn_I(m_wrn),
    .M_CSn_I(m_csn),
    .F56_BADD_O(f_badd),
    .F56_BADD_DIR_O(f_dir),
    .F56_ALE_O(f_ale),
    .F56_RDn_O(f_rdn),
    .F56_WRn_O(f_wrn),
    .F56_CSn_O(f_csn),
    .BUSY_O(busy),
    .OWNER_O(owner),
    .TIMEOUT_O(tout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s @%0t: observed=%h expected=%h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [13:0] master_pins(input int i);
    return {m_badd[8*i +: 8], m_dir[i], m_ale[i], m_rdn[i], m_wrn[i], m_csn[2*i +: 2]};
  endfunction

  // Search starting one past the pointer, wrapping, first requester wins.
  task automatic arbitrate();
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (md_ptr + k) % N;
      if (req[j]) begin
        md_owner = j;
        md_ptr   = j;
        md_last  = j;
        md_age   = 0;
        return;
      end
    end
  endtask

  task automatic model_edge();
    md_to = 1'b0;
    if (rst) begin
      md_owner    = -1;
      md_age      = 0;
      md_gap_left = 0;
      md_ptr      = N - 1;
      md_last     = 0;
      md_pins     = PIN_IDLE;
    end else if (md_owner >= 0) begin
      if (!req[md_owner]) begin
        md_owner    = -1;
        md_gap_left = GAP;
        md_pins     = PIN_IDLE;
      end else if (TO_EN && (md_age + 1 >= HOLD)) begin
        md_owner    = -1;
        md_gap_left = GAP;
        md_pins     = PIN_IDLE;
        md_to       = 1'b1;
      end else begin
        md_age++;
        md_pins = master_pins(md_owner);
      end
    end else if (md_gap_left > 0) begin
      md_pins = PIN_IDLE;
      md_gap_left--;
      if (md_gap_left == 0) arbitrate();
    end else begin
      md_pins = PIN_IDLE;
      arbitrate();
    end
  endtask

  task automatic compare_all();
    logic [3:0] exp_gnt;
    exp_gnt = (md_owner >= 0) ? (4'b0001 << md_owner) : 4'b0000;
    check("gnt", 32'(gnt), 32'(exp_gnt));
    check("pins", 32'({f_badd, f_dir, f_ale, f_rdn, f_wrn, f_csn}), 32'(md_pins));
    check("busy", 32'(busy), 32'((md_owner >= 0) || (md_gap_left > 0)));
    check("owner", 32'(owner), 32'(md_last));
    check("timeout", 32'(tout), 32'(md_to));
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
    end
  endtask

  task automatic idle_masters();
    m_badd = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
    m_dir  = 4'b0000;
    m_ale  = 4'b0000;
    m_rdn  = 4'b1111;
    m_wrn  = 4'b1111;
    m_csn  = 8'hFF;
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b1111;
    idle_masters();
    md_owner = -1; md_age = 0; md_gap_left = 0; md_ptr = N - 1; md_last = 0;
    md_pins = PIN_IDLE; md_to = 1'b0;

    // Reset with all masters requesting
    tick(2);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    tick(1);

    // Round-robin order 0,1,2,3,0 with a 2-cycle gap between grants
    for (int s = 0; s < 5; s++) begin
      check("rr_order", 32'(gnt), 32'(4'b0001 << (s % 4)));
      tick(2);
      req[s % 4] = 1'b0;
      tick(1);
      check("rr_release", 32'(gnt), 32'h0);
      req[s % 4] = 1'b1;
      tick(1);
      check("rr_gap", 32'(gnt), 32'h0);
      tick(1);
    end
    req = 4'b0000;
    tick(5);

    // Master 2 alone: pins follow its signals one cycle late
    m_badd[23:16] = 8'h5A;
    m_ale[2] = 1'b1;
    req = 4'b0100;
    tick(1);
    check("m2_grant", 32'(gnt), 32'h4);
    check("m2_pins_idle_pre", 32'(f_badd), 32'h00);
    tick(1);
    check("m2_badd", 32'(f_badd), 32'h5A);
    check("m2_ale", 32'(f_ale), 32'h1);
    m_csn[5:4] = 2'b10;
    m_rdn[2] = 1'b0;
    tick(1);
    check("m2_csn", 32'(f_csn), 32'h2);
    check("m2_rdn", 32'(f_rdn), 32'h0);
    req = 4'b0000;
    tick(1);
    check("m2_pins_idle_post", 32'({f_badd, f_rdn, f_wrn, f_csn}), 32'({8'h00, 1'b1, 1'b1, 2'b11}));
    tick(3);
    idle_masters();

    // Master 1 owns the bus while master 3 waits
    req = 4'b0010;
    tick(1);
    req = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      tick(1);
      check("m1_not_m3", 32'(f_badd), 32'hC1);
    end
    req = 4'b1000;
    tick(1);
    tick(1);
    check("m3_wait", 32'(gnt), 32'h0);
    tick(1);
    check("m3_grant", 32'(gnt), 32'h8);
    req = 4'b0000;
    tick(4);

    // Long hold by master 0 with master 1 pending
    req = 4'b0001;
    tick(1);
    req = 4'b0011;
    tick(HOLD - 1);
    check("hold_g63", 32'(gnt), 32'h1);
    tick(1);
`ifdef F56_ARB_TIMEOUT_EN
    check("to_gnt", 32'(gnt), 32'h0);
    check("to_pulse", 32'(tout), 32'h1);
    tick(1);
    check("to_pulse_end", 32'(tout), 32'h0);
    tick(1);
    check("to_next_m1", 32'(gnt), 32'h2);
`else
    check("noto_gnt", 32'(gnt), 32'h1);
    tick(200 - HOLD);
    check("noto_g200", 32'(gnt), 32'h1);
    check("noto_tout", 32'(tout), 32'h0);
`endif
    req = 4'b0000;
    tick(4);

    // Master 0 releases exactly on the timeout edge
    req = 4'b0001;
    tick(1);
    tick(HOLD - 1);
    req = 4'b0000;
    tick(1);
    check("rel_at_to_gnt", 32'(gnt), 32'h0);
    check("rel_at_to_tout", 32'(tout), 32'h0);
    tick(3);

    // Reset in the middle of master 1's write strobe
    m_wrn[1] = 1'b0;
    m_csn[3:2] = 2'b01;
    req = 4'b0010;
    tick(2);
    check("strobe_wrn", 32'(f_wrn), 32'h0);
    rst = 1'b1;
    req = 4'b0011;
    tick(1);
    check("rst_mid_gnt", 32'(gnt), 32'h0);
    check("rst_mid_wrn", 32'(f_wrn), 32'h1);
    check("rst_mid_csn", 32'(f_csn), 32'h3);
    check("rst_mid_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    tick(1);
    check("rst_restart_m0", 32'(gnt), 32'h1);

    // Random phase
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) req[$urandom_range(0, 3)] ^= 1'b1;
      rst    = ($urandom_range(0, 199) == 0);
      m_badd = $urandom();
      m_dir  = 4'($urandom());
      m_ale  = 4'($urandom());
      m_rdn  = 4'($urandom());
      m_wrn  = 4'($urandom());
      m_csn  = 8'($urandom());
      tick(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/f56_bus_arbiter.md
# f56_bus_arbiter

Round-robin arbiter and pin multiplexer for the shared FALC56 local bus (BADD/ALE/RDn/WRn/CSn). Sits between the FALC56 pins and up to NUM_REQ bus masters: the Wishbone register bridge, the interrupt service engine and the init sequencer. Each master raises a request, waits for its one-hot grant, drives its own copy of the bus signals, then drops the request. The arbiter forwards the owner's signals to the pins, parks the pins idle otherwise, and enforces a turnaround gap plus an optional maximum hold time.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- OWN_W, 2, width of owner index; must be ≥ ceil(log2(NUM_REQ))
- GAP_CYCLES, 2, idle turnaround cycles after each release (≥1)
- MAX_HOLD, 64, maximum cycles a grant may be held (≥2, ≤1024)

- PHY_CLK33_I  in  1  bus clock; one clock, all logic on rising edge
- PHY_RST_I  in  1  reset, synchronous, active-high
- REQ_I  in  NUM_REQ  per-master request, level
- GNT_O  out  NUM_REQ  one-hot grant, registered
- M_BADD_I  in  8*NUM_REQ  per-master address/data out, master i at [8i+7:8i]
- M_BADD_DIR_I  in  NUM_REQ  per-master bus drive enable
- M_ALE_I  in  NUM_REQ  per-master ALE
- M_RDn_I  in  NUM_REQ  per-master RDn
- M_WRn_I  in  NUM_REQ  per-master WRn
- M_CSn_I  in  2*NUM_REQ  per-master CSn pair, master i at [2i+1:2i]
- F56_BADD_O  out  8  pin address/data out
- F56_BADD_DIR_O  out  1  pin drive enable
- F56_ALE_O  out  1  pin ALE
- F56_RDn_O  out  1  pin RDn
- F56_WRn_O  out  1  pin WRn
- F56_CSn_O  out  2  pin chip selects
- BUSY_O  out  1  high in GRANT or GAP
- OWNER_O  out  OWN_W  index of current or last owner
- TIMEOUT_O  out  1  one-cycle pulse on forced revoke

## Operation
- States: IDLE, GRANT, GAP.
- Idle pin values: BADD=0x00, BADD_DIR=0, ALE=0, RDn=1, WRn=1, CSn=2'b11.
- Reset: state IDLE. GNT_O=0, pins idle, BUSY_O=0, OWNER_O=0, TIMEOUT_O=0. Round-robin pointer=NUM_REQ-1, so master 0 has first priority. Hold and gap counters are 0.
- Arbitration: search REQ_I starting at pointer+1 with wrap to 0, and take the first set bit. The winner's GNT_O bit is set, OWNER_O and pointer are loaded with the winner, the hold counter is cleared, and the state moves to GRANT.
- IDLE: arbitrate every edge while REQ_I≠0.
- GRANT, pins: each edge, the pins register the owner's M_* signals.
- GRANT, hold counter: increments each edge while REQ_I[owner]=1.
- GRANT, release: REQ_I[owner]=0 at an edge clears GNT_O, forces pins idle and moves to GAP.
- GAP: pins idle, GNT_O=0, gap counter increments. On the edge where the counter reaches GAP_CYCLES-1, arbitrate if any REQ_I is set (go to GRANT), else go to IDLE.
- Requests from non-owners are ignored during GRANT and GAP. They are stateless: a request dropped before arbitration is lost.
- Out-of-range REQ_I bits (above NUM_REQ-1) do not exist. Unused OWN_W bits are 0.

## Timing
- Grant latency: REQ_I sampled high in IDLE at edge k gives GNT_O high after edge k (1 cycle).
- Pin latency: master signals reach the pins 1 cycle later, registered at every edge in GRANT.
- Release: REQ_I low sampled at edge m gives GNT_O=0 and pins idle after edge m. The next grant comes at edge m+GAP_CYCLES at the earliest.
- Forced revoke (macro enabled): granted at edge g with REQ_I[owner] held high gives revoke at edge g+MAX_HOLD. At that edge GNT_O clears, pins go idle, TIMEOUT_O=1 for exactly one cycle, and the state moves to GAP. Pointer stays at the revoked owner, so others are served first. The revoked master is re-granted after GAP if it is the only requester.
- Simultaneous release and timeout on the same edge counts as a normal release: no TIMEOUT_O.
- Reset mid-grant: at the reset edge all outputs take their reset values. No partial strobe is extended.

## Configuration
- F56_ARB_TIMEOUT_EN defined: the hold limit MAX_HOLD is enforced and TIMEOUT_O pulses as above.
- Not defined: the hold counter is not built, a grant persists until release, and TIMEOUT_O is tied to 0.

## Test plan
- Reset with REQ_I=4'b1111 held: first GNT_O=0001 one edge after reset release. After master 0 drops, grants follow 0010, 0100, 1000, 0001 in order. Each pair of grants is separated by exactly GAP_CYCLES=2 cycles with GNT_O=0 and pins idle.
- Master 2 alone drives M_BADD=0x5A, ALE=1, then CSn=2'b10, RDn=0: F56 pins show the same values, 1 cycle delayed. Pins are idle (0x00, 1, 1, 2'b11) both before the grant and after the release.
- Master 1 is granted while master 3 requests: pins never show master 3's values. Master 3 is granted 2 cycles after master 1 releases.
- F56_ARB_TIMEOUT_EN, MAX_HOLD=64, master 0 holds its request: GNT_O clears at grant+64, TIMEOUT_O pulses once, and a pending master 1 is granted 2 cycles later. Without the macro, the grant is still held at grant+200 and TIMEOUT_O stays 0.
- Master 0 drops REQ_I on exactly the timeout edge: the release is normal with TIMEOUT_O=0.
- PHY_RST_I asserted for 1 cycle during master 1's WRn=0 strobe: after the next edge GNT_O=0, F56_WRn_O=1, F56_CSn_O=2'b11, BUSY_O=0, and arbitration restarts from master 0.
